// File: rtl/pci_pkg.sv
// Shared PCI initiator definitions: bus command codes, FSM state encoding
// and the burst-length clamp applied to local requests.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam int DEFAULT_DEVSEL_TIMEOUT = 5;
  localparam int DEFAULT_MAX_LEN        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ENDING,
    ST_TURN
  } pci_state_e;

  // A zero length still moves one word; oversize requests are cut to max_len.
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_len);
    if (len == 5'd0) return 5'd1;
    if (int'(len) > max_len) return 5'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/pci_wdata_hold.sv
// One-entry write-data buffer between local logic and the AD bus; it refills
// on the same edge it is emptied so a zero-wait target sees one word per clock.
module pci_wdata_hold (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic        pop,
  output logic        full,
  output logic [31:0] data,
  output logic        wr_ack
);

  logic        full_d, full_q;
  logic [31:0] data_d, data_q;
  logic        load;

  always_comb begin
    load   = wr_valid && (!full_q || pop) && !rst;
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 32'h0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full   = full_q;
  assign data   = data_q;
  assign wr_ack = load;

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: turns one local burst request into a single PCI memory
// read or write, handling wait states, write stalls, disconnect and master abort.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int DEVSEL_TIMEOUT = DEFAULT_DEVSEL_TIMEOUT,
  parameter int MAX_LEN        = DEFAULT_MAX_LEN
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        CMD_WRITE,
  input  logic [31:0] ADDR,
  input  logic [4:0]  LEN,
  input  logic [3:0]  BE,
  input  logic [31:0] WR_DATA,
  input  logic        WR_VALID,
  output logic        WR_ACK,
  output logic [31:0] RD_DATA,
  output logic        RD_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [4:0]  XFER_CNT,
  output logic        FRAME,
  inout  wire  [31:0] AD,
  output logic [3:0]  CBE,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        STOP
);

  localparam int DCW = (DEVSEL_TIMEOUT > 1) ? $clog2(DEVSEL_TIMEOUT) : 1;

  pci_state_e  state_d, state_q;
  logic [31:0] addr_d, addr_q;
  logic [3:0]  be_d, be_q;
  logic        write_d, write_q;
  logic [4:0]  remaining_d, remaining_q;
  logic [4:0]  xfer_cnt_d, xfer_cnt_q;
  logic [DCW-1:0] dev_cnt_d, dev_cnt_q;
  logic        devsel_seen_d, devsel_seen_q;
  logic        abort_d, abort_q;
  logic [31:0] rd_data_d, rd_data_q;
  logic        rd_valid_d, rd_valid_q;

  logic        frame_n, irdy_n, ad_oe, phase_done, abort_hit, pop;
  logic [3:0]  cbe_n;
  logic [31:0] ad_out;
  logic        hold_full;
  logic [31:0] hold_data;

  pci_wdata_hold u_hold (
    .clk      (CLK),
    .rst      (RST),
    .wr_data  (WR_DATA),
    .wr_valid (WR_VALID),
    .pop      (pop),
    .full     (hold_full),
    .data     (hold_data),
    .wr_ack   (WR_ACK)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    write_d       = write_q;
    remaining_d   = remaining_q;
    xfer_cnt_d    = xfer_cnt_q;
    dev_cnt_d     = dev_cnt_q;
    devsel_seen_d = devsel_seen_q;
    abort_d       = abort_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    frame_n       = 1'b1;
    irdy_n        = 1'b1;
    cbe_n         = 4'hF;
    ad_oe         = 1'b0;
    ad_out        = hold_data;
    phase_done    = 1'b0;
    abort_hit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d        = ADDR;
          be_d          = BE;
          write_d       = CMD_WRITE;
          remaining_d   = clamp_len(LEN, MAX_LEN);
          xfer_cnt_d    = 5'd0;
          dev_cnt_d     = '0;
          devsel_seen_d = 1'b0;
          abort_d       = 1'b0;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        frame_n = 1'b0;
        ad_oe   = 1'b1;
        ad_out  = addr_q;
        cbe_n   = write_q ? CMD_MEM_WRITE : CMD_MEM_READ;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        cbe_n      = be_q;
        frame_n    = (remaining_q == 5'd1);
        irdy_n     = write_q ? !hold_full : 1'b0;
        ad_oe      = write_q;
        phase_done = !irdy_n && !TRDY && !DEVSEL;
        if (phase_done) begin
          remaining_d = remaining_q - 5'd1;
          xfer_cnt_d  = xfer_cnt_q + 5'd1;
          rd_valid_d  = !write_q;
          rd_data_d   = write_q ? rd_data_q : AD;
        end
        // Abort only if no target has claimed the cycle by the timeout edge.
        if (!devsel_seen_q) begin
          if (!DEVSEL) devsel_seen_d = 1'b1;
          else if (dev_cnt_q == DCW'(DEVSEL_TIMEOUT - 1)) abort_hit = 1'b1;
          else dev_cnt_d = dev_cnt_q + DCW'(1);
        end
        if (abort_hit) begin
          abort_d = 1'b1;
          state_d = ST_ENDING;
        end else if (phase_done && remaining_q == 5'd1) begin
          state_d = ST_TURN;
        end else if (!STOP && !frame_n) begin
          state_d = ST_ENDING;
        end
      end
      ST_ENDING: begin
        irdy_n  = 1'b0;
        cbe_n   = be_q;
        ad_oe   = write_q;
        state_d = ST_TURN;
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      addr_q        <= 32'h0;
      be_q          <= 4'h0;
      write_q       <= 1'b0;
      remaining_q   <= 5'd0;
      xfer_cnt_q    <= 5'd0;
      dev_cnt_q     <= '0;
      devsel_seen_q <= 1'b0;
      abort_q       <= 1'b0;
      rd_data_q     <= 32'h0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      write_q       <= write_d;
      remaining_q   <= remaining_d;
      xfer_cnt_q    <= xfer_cnt_d;
      dev_cnt_q     <= dev_cnt_d;
      devsel_seen_q <= devsel_seen_d;
      abort_q       <= abort_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign pop      = phase_done && write_q;
  assign AD       = ad_oe ? ad_out : 32'hzzzz_zzzz;
  assign FRAME    = frame_n;
  assign IRDY     = irdy_n;
  assign CBE      = cbe_n;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_TURN);
  assign ERROR    = (state_q == ST_TURN) && abort_q;
  assign XFER_CNT = xfer_cnt_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: the bench plays the PCI target and the
// local requester cycle by cycle and compares against hand-derived values.
module tb_pci_initiator;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        CMD_WRITE;
  logic [31:0] ADDR;
  logic [4:0]  LEN;
  logic [3:0]  BE;
  logic [31:0] WR_DATA;
  logic        WR_VALID;
  logic        WR_ACK;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [4:0]  XFER_CNT;
  logic        FRAME;
  wire  [31:0] AD;
  logic [3:0]  CBE;
  logic        IRDY;
  logic        TRDY;
  logic        DEVSEL;
  logic        STOP;

  logic [31:0] tb_ad;
  logic        tb_ad_oe;

  int check_count;
  int pass_count;

  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

  // Released AD floats high through the pullups, so "released" reads as all ones.
  assign AD = tb_ad_oe ? tb_ad : 32'hzzzz_zzzz;
  for (genvar i = 0; i < 32; i++) begin : g_pull
    pullup (AD[i]);
  end

  pci_initiator dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .CMD_WRITE (CMD_WRITE),
    .ADDR      (ADDR),
    .LEN       (LEN),
    .BE        (BE),
    .WR_DATA   (WR_DATA),
    .WR_VALID  (WR_VALID),
    .WR_ACK    (WR_ACK),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR),
    .XFER_CNT  (XFER_CNT),
    .FRAME     (FRAME),
    .AD        (AD),
    .CBE       (CBE),
    .IRDY      (IRDY),
    .TRDY      (TRDY),
    .DEVSEL    (DEVSEL),
    .STOP      (STOP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [4:0] l,
                               input logic [3:0] be);
    START = 1'b1; CMD_WRITE = wr; ADDR = a; LEN = l; BE = be;
    step();
    START = 1'b0; ADDR = 32'h0; LEN = 5'd0;
  endtask

  logic [31:0] w2 [7];
  logic [31:0] rdw [4];
  logic [31:0] rx [$];
  logic [31:0] got_word;
  int wr_idx;

  initial begin
    check_count = 0; pass_count = 0;
    RST = 1'b1; START = 1'b0; CMD_WRITE = 1'b0; ADDR = 32'h0; LEN = 5'd0; BE = 4'h0;
    WR_DATA = 32'hDEAD_BEEF; WR_VALID = 1'b1;
    TRDY = 1'b1; DEVSEL = 1'b1; STOP = 1'b1; tb_ad = 32'h0; tb_ad_oe = 1'b0;
    for (int i = 0; i < 7; i++) w2[i] = 32'h0000_f0f0 + 32'(i);
    for (int i = 0; i < 4; i++) rdw[i] = 32'hA5A5_00A0 + 32'(i);

    // reset state
    step(); step(); #1;
    checkOutput("rst frame", 32'(FRAME), 32'd1);
    checkOutput("rst irdy", 32'(IRDY), 32'd1);
    checkOutput("rst cbe", 32'(CBE), 32'hF);
    checkOutput("rst ad", AD, RELEASED);
    checkOutput("rst busy", 32'(BUSY), 32'd0);
    checkOutput("rst done", 32'(DONE), 32'd0);
    checkOutput("rst wr_ack", 32'(WR_ACK), 32'd0);
    checkOutput("rst xfer", 32'(XFER_CNT), 32'd0);
    WR_VALID = 1'b0; RST = 1'b0;
    step();

    // single write
    WR_DATA = 32'h0000_f0f0; WR_VALID = 1'b1; #1;
    checkOutput("t1 preload ack", 32'(WR_ACK), 32'd1);
    step(); WR_VALID = 1'b0;
    applyStimulus(1'b1, 32'hffff_0000, 5'd1, 4'h0); #1;
    checkOutput("t1 addr frame", 32'(FRAME), 32'd0);
    checkOutput("t1 addr ad", AD, 32'hffff_0000);
    checkOutput("t1 addr cbe", 32'(CBE), 32'h7);
    checkOutput("t1 addr busy", 32'(BUSY), 32'd1);
    step(); DEVSEL = 1'b0; TRDY = 1'b0; #1;
    checkOutput("t1 data frame", 32'(FRAME), 32'd1);
    checkOutput("t1 data irdy", 32'(IRDY), 32'd0);
    checkOutput("t1 data ad", AD, 32'h0000_f0f0);
    checkOutput("t1 data cbe", 32'(CBE), 32'h0);
    step(); DEVSEL = 1'b1; TRDY = 1'b1; #1;
    checkOutput("t1 done", 32'(DONE), 32'd1);
    checkOutput("t1 xfer", 32'(XFER_CNT), 32'd1);
    checkOutput("t1 error", 32'(ERROR), 32'd0);
    checkOutput("t1 turn ad", AD, RELEASED);
    step(); #1;
    checkOutput("t1 idle busy", 32'(BUSY), 32'd0);

    // write burst with a target wait state and a local write stall
    WR_DATA = w2[0]; WR_VALID = 1'b1; #1;
    checkOutput("t2 preload ack", 32'(WR_ACK), 32'd1);
    step(); wr_idx = 1; WR_DATA = w2[1];
    applyStimulus(1'b1, 32'h1000_0000, 5'd7, 4'h3);
    rx.delete();
    for (int d = 1; d <= 9; d++) begin
      step();
      DEVSEL = 1'b0;
      TRDY = (d == 3);
      WR_VALID = (wr_idx < 7) && (d != 4);
      WR_DATA = w2[(wr_idx < 7) ? wr_idx : 6];
      #1;
      checkOutput($sformatf("t2 frame d%0d", d), 32'(FRAME), 32'(d == 9));
      if (d == 5) checkOutput("t2 irdy gap", 32'(IRDY), 32'd1);
      if (!IRDY && !TRDY && !DEVSEL) rx.push_back(AD);
      if (WR_ACK) wr_idx++;
    end
    step(); TRDY = 1'b1; DEVSEL = 1'b1; WR_VALID = 1'b0; #1;
    checkOutput("t2 done", 32'(DONE), 32'd1);
    checkOutput("t2 xfer", 32'(XFER_CNT), 32'd7);
    checkOutput("t2 rx count", 32'(rx.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      got_word = (i < rx.size()) ? rx[i] : 32'hDEAD_DEAD;
      checkOutput($sformatf("t2 rx word%0d", i), got_word, w2[i]);
    end
    step(); #1;
    checkOutput("t2 idle busy", 32'(BUSY), 32'd0);

    // read burst with late DEVSEL
    applyStimulus(1'b0, 32'h2000_0040, 5'd4, 4'hF); #1;
    checkOutput("t3 addr cbe", 32'(CBE), 32'h6);
    checkOutput("t3 addr ad", AD, 32'h2000_0040);
    step(); #1;
    checkOutput("t3 d1 ad released", AD, RELEASED);
    checkOutput("t3 d1 irdy", 32'(IRDY), 32'd0);
    for (int d = 2; d <= 5; d++) begin
      step();
      DEVSEL = 1'b0; TRDY = 1'b0; tb_ad_oe = 1'b1; tb_ad = rdw[d-2];
      #1;
      checkOutput($sformatf("t3 rd_valid d%0d", d), 32'(RD_VALID), 32'(d > 2));
      if (d > 2) checkOutput($sformatf("t3 rd_data d%0d", d), RD_DATA, rdw[d-3]);
      checkOutput($sformatf("t3 frame d%0d", d), 32'(FRAME), 32'(d == 5));
    end
    step(); tb_ad_oe = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1; #1;
    checkOutput("t3 last rd_valid", 32'(RD_VALID), 32'd1);
    checkOutput("t3 last rd_data", RD_DATA, rdw[3]);
    checkOutput("t3 done", 32'(DONE), 32'd1);
    checkOutput("t3 xfer", 32'(XFER_CNT), 32'd4);
    step(); #1;
    checkOutput("t3 idle rd_valid", 32'(RD_VALID), 32'd0);
    checkOutput("t3 idle busy", 32'(BUSY), 32'd0);

    // master abort
    applyStimulus(1'b0, 32'h3000_0000, 5'd2, 4'hF);
    for (int d = 1; d <= 5; d++) begin
      step(); #1;
      checkOutput($sformatf("t4 frame d%0d", d), 32'(FRAME), 32'd0);
    end
    step(); #1;
    checkOutput("t4 ending frame", 32'(FRAME), 32'd1);
    checkOutput("t4 ending irdy", 32'(IRDY), 32'd0);
    checkOutput("t4 ending done", 32'(DONE), 32'd0);
    step(); #1;
    checkOutput("t4 done", 32'(DONE), 32'd1);
    checkOutput("t4 error", 32'(ERROR), 32'd1);
    checkOutput("t4 xfer", 32'(XFER_CNT), 32'd0);
    step(); #1;
    checkOutput("t4 idle frame", 32'(FRAME), 32'd1);
    checkOutput("t4 idle irdy", 32'(IRDY), 32'd1);
    checkOutput("t4 idle cbe", 32'(CBE), 32'hF);
    checkOutput("t4 idle ad", AD, RELEASED);
    checkOutput("t4 idle error", 32'(ERROR), 32'd0);
    checkOutput("t4 idle busy", 32'(BUSY), 32'd0);

    // target disconnect with data on the second transfer
    applyStimulus(1'b0, 32'h4000_0000, 5'd8, 4'hF);
    step(); DEVSEL = 1'b0; TRDY = 1'b0; tb_ad_oe = 1'b1; tb_ad = 32'hB0B0_0000; #1;
    step(); STOP = 1'b0; tb_ad = 32'hB0B0_0001; #1;
    checkOutput("t5 stop frame", 32'(FRAME), 32'd0);
    step(); TRDY = 1'b1; tb_ad_oe = 1'b0; #1;
    checkOutput("t5 ending frame", 32'(FRAME), 32'd1);
    checkOutput("t5 ending irdy", 32'(IRDY), 32'd0);
    checkOutput("t5 ending rd_valid", 32'(RD_VALID), 32'd1);
    checkOutput("t5 ending rd_data", RD_DATA, 32'hB0B0_0001);
    checkOutput("t5 ending done", 32'(DONE), 32'd0);
    step(); STOP = 1'b1; DEVSEL = 1'b1; #1;
    checkOutput("t5 done", 32'(DONE), 32'd1);
    checkOutput("t5 error", 32'(ERROR), 32'd0);
    checkOutput("t5 xfer", 32'(XFER_CNT), 32'd2);
    step(); #1;
    checkOutput("t5 idle busy", 32'(BUSY), 32'd0);

    // reset in the middle of a write burst
    WR_DATA = 32'h0000_f1f0; WR_VALID = 1'b1;
    step(); WR_DATA = 32'h0000_f1f1;
    applyStimulus(1'b1, 32'h5000_0000, 5'd5, 4'hF);
    step(); DEVSEL = 1'b0; TRDY = 1'b0; #1;
    step(); WR_DATA = 32'h0000_f1f2; #1;
    step(); WR_DATA = 32'h0000_f1f3; #1;
    checkOutput("t6 word3 ad", AD, 32'h0000_f1f2);
    #2; RST = 1'b1; #1;
    checkOutput("t6 rst frame", 32'(FRAME), 32'd1);
    checkOutput("t6 rst irdy", 32'(IRDY), 32'd1);
    checkOutput("t6 rst cbe", 32'(CBE), 32'hF);
    checkOutput("t6 rst ad", AD, RELEASED);
    checkOutput("t6 rst busy", 32'(BUSY), 32'd0);
    checkOutput("t6 rst xfer", 32'(XFER_CNT), 32'd0);
    checkOutput("t6 rst wr_ack", 32'(WR_ACK), 32'd0);
    step(); DEVSEL = 1'b1; TRDY = 1'b1;
    RST = 1'b0; WR_DATA = 32'h1234_5678; WR_VALID = 1'b1; #1;
    checkOutput("t6 hold emptied", 32'(WR_ACK), 32'd1);
    step(); WR_VALID = 1'b0;
    applyStimulus(1'b1, 32'h6000_0000, 5'd1, 4'h5); #1;
    checkOutput("t6 addr frame", 32'(FRAME), 32'd0);
    checkOutput("t6 addr ad", AD, 32'h6000_0000);
    checkOutput("t6 addr cbe", 32'(CBE), 32'h7);
    step(); DEVSEL = 1'b0; TRDY = 1'b0; #1;
    checkOutput("t6 data ad", AD, 32'h1234_5678);
    checkOutput("t6 data irdy", 32'(IRDY), 32'd0);
    checkOutput("t6 data cbe", 32'(CBE), 32'h5);
    step(); DEVSEL = 1'b1; TRDY = 1'b1; #1;
    checkOutput("t6 done", 32'(DONE), 32'd1);
    checkOutput("t6 xfer", 32'(XFER_CNT), 32'd1);
    step(); #1;
    checkOutput("t6 idle busy", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
